// File: rtl/sd_spi_activity_if.sv
// Core-side SD SPI pins plus the activity monitor's indications.
// master drives the SPI pins; slave is the passive monitor.
interface sd_spi_activity_if;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_ss;
    logic        led_user;
    logic [1:0]  led_disk;
    logic        busy;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    modport master (
        output spi_sck, spi_mosi, spi_miso, spi_ss,
        input  led_user, led_disk, busy, cmd_valid, cmd_index, cmd_arg
    );

    modport slave (
        input  spi_sck, spi_mosi, spi_miso, spi_ss,
        output led_user, led_disk, busy, cmd_valid, cmd_index, cmd_arg
    );
endinterface

// File: rtl/sd_spi_activity.sv
// Passive SD SPI monitor: stretched activity LEDs, bus-idle flag, command decode.
// Define SD_SPI_ACT_CMDLOG_EN to build the command-frame decoder and data-command LED.
module sd_spi_activity #(
    parameter int unsigned STRETCH_CYCLES = 2500000,
    parameter int unsigned IDLE_TIMEOUT   = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    sd_spi_activity_if.slave bus
);
    localparam logic [31:0] RELOAD   = 32'(STRETCH_CYCLES - 1);
    localparam logic [31:0] IDLE_MAX = 32'(IDLE_TIMEOUT);

    logic        sck_s1, sck_s2, mosi_s1, mosi_s2, miso_s1, miso_s2, ss_s1, ss_s2;
    logic        mosi_s3, miso_s3;
    logic        sck_rise;
    logic [31:0] act_cnt;
    logic        led_user_q;
    logic [31:0] idle_cnt;
    logic        busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            {sck_s1, sck_s2, mosi_s1, mosi_s2, miso_s1, miso_s2} <= '0;
            {ss_s1, ss_s2, mosi_s3, miso_s3}                     <= '0;
        end else begin
            sck_s1  <= bus.spi_sck;
            sck_s2  <= sck_s1;
            mosi_s1 <= bus.spi_mosi;
            mosi_s2 <= mosi_s1;
            miso_s1 <= bus.spi_miso;
            miso_s2 <= miso_s1;
            ss_s1   <= bus.spi_ss;
            ss_s2   <= ss_s1;
            mosi_s3 <= mosi_s2;
            miso_s3 <= miso_s2;
        end
    end

    assign sck_rise = sck_s1 & ~sck_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_cnt    <= '0;
            led_user_q <= 1'b0;
        end else begin
            if (sck_rise && !ss_s2) begin
                act_cnt <= RELOAD;
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 32'd1;
            end
            led_user_q <= (act_cnt != '0);
        end
    end

    // busy drops on the cycle idle_cnt saturates at IDLE_MAX
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
            busy_q   <= 1'b0;
        end else if ((mosi_s2 != mosi_s3) || (miso_s2 != miso_s3)) begin
            idle_cnt <= '0;
            busy_q   <= 1'b1;
        end else if (idle_cnt < IDLE_MAX - 32'd1) begin
            idle_cnt <= idle_cnt + 32'd1;
        end else begin
            idle_cnt <= IDLE_MAX;
            busy_q   <= 1'b0;
        end
    end

    assign bus.led_user = led_user_q;
    assign bus.busy     = busy_q;

`ifdef SD_SPI_ACT_CMDLOG_EN
    typedef enum logic [1:0] {IDLE, ARG, CRC} state_t;

    state_t      state;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        byte_done;
    logic [1:0]  arg_cnt;
    logic [5:0]  idx_pend;
    logic [31:0] arg_pend;
    logic        cmd_valid_q;
    logic [5:0]  cmd_index_q;
    logic [31:0] cmd_arg_q;
    logic [31:0] dsk_cnt;
    logic        led_disk_q;

    // byte_done is registered, so the FSM reads the freshly completed byte from shift
    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (ss_s2) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift   <= {shift[6:0], mosi_s2};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            arg_cnt     <= '0;
            idx_pend    <= '0;
            arg_pend    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (ss_s2) begin
                state <= IDLE;
            end else if (byte_done) begin
                case (state)
                    IDLE: begin
                        if (shift[7:6] == 2'b01) begin
                            idx_pend <= shift[5:0];
                            arg_cnt  <= '0;
                            state    <= ARG;
                        end
                    end
                    ARG: begin
                        arg_pend <= {arg_pend[23:0], shift};
                        arg_cnt  <= arg_cnt + 2'd1;
                        if (arg_cnt == 2'd3) begin
                            state <= CRC;
                        end
                    end
                    CRC: begin
                        cmd_valid_q <= 1'b1;
                        cmd_index_q <= idx_pend;
                        cmd_arg_q   <= arg_pend;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsk_cnt    <= '0;
            led_disk_q <= 1'b0;
        end else begin
            if (cmd_valid_q && (cmd_index_q inside {6'd17, 6'd18, 6'd24, 6'd25})) begin
                dsk_cnt <= RELOAD;
            end else if (dsk_cnt != '0) begin
                dsk_cnt <= dsk_cnt - 32'd1;
            end
            led_disk_q <= (dsk_cnt != '0);
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_index = cmd_index_q;
    assign bus.cmd_arg   = cmd_arg_q;
    assign bus.led_disk  = {1'b0, led_disk_q};
`else
    assign bus.cmd_valid = 1'b0;
    assign bus.cmd_index = '0;
    assign bus.cmd_arg   = '0;
    assign bus.led_disk  = {1'b0, led_user_q};
`endif
endmodule

// File: tb/tb_sd_spi_activity.sv
// Bench for sd_spi_activity: SPI master stimulus at clk/8, scoreboard of decoded frames.
module tb_sd_spi_activity;
`ifdef SD_SPI_ACT_CMDLOG_EN
    localparam bit CMDLOG = 1'b1;
`else
    localparam bit CMDLOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned last_rise = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [37:0] exp_q[$];
    logic [37:0] mon_exp;

    sd_spi_activity_if bus ();

    sd_spi_activity #(
        .STRETCH_CYCLES(100),
        .IDLE_TIMEOUT  (50)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // frame scoreboard: every cmd_valid pulse must match the oldest pushed frame
    always @(negedge clk) begin
        if (bus.cmd_valid !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected: cmd_valid=%b idx=%0d arg=%h, expected no frame",
                         bus.cmd_valid, bus.cmd_index, bus.cmd_arg);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.cmd_index, bus.cmd_arg} !== mon_exp) begin
                    failures++;
                    $display("FAIL cmd_frame: idx=%0d arg=%h, expected idx=%0d arg=%h",
                             bus.cmd_index, bus.cmd_arg, mon_exp[37:32], mon_exp[31:0]);
                end
                checks++;
                if (cyc !== last_rise + 2) begin
                    failures++;
                    $display("FAIL cmd_latency: pulse at cycle %0d, expected %0d", cyc, last_rise + 2);
                end
            end
        end
    end

    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ss_at_end);
        for (int unsigned i = 0; i < 8; i++) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = b[7-i];
            repeat (4) @(negedge clk);
            bus.spi_sck = 1'b1;
            if (i == 7) begin
                last_rise = cyc + 1;
                if (ss_at_end) bus.spi_ss = 1'b1;
            end
            repeat (4) @(negedge clk);
        end
        bus.spi_sck = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [7:0] crc, input bit push, input bit ss_at_end);
        bus.spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        if (push) exp_q.push_back({idx, arg});
        send_byte({2'b01, idx}, 1'b0);
        send_byte(arg[31:24], 1'b0);
        send_byte(arg[23:16], 1'b0);
        send_byte(arg[15:8], 1'b0);
        send_byte(arg[7:0], 1'b0);
        send_byte(crc, ss_at_end);
    endtask

    task automatic test_reset();
        bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0; bus.spi_miso = 1'b0; bus.spi_ss = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.led_user !== 1'b0) begin failures++; $display("FAIL reset_led_user: %b expected 0", bus.led_user); end
        checks++; if (bus.led_disk !== 2'b00) begin failures++; $display("FAIL reset_led_disk: %b expected 00", bus.led_disk); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: %b expected 0", bus.busy); end
        checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid: %b expected 0", bus.cmd_valid); end
        checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL reset_cmd_index: %0d expected 0", bus.cmd_index); end
        checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL reset_cmd_arg: %h expected 0", bus.cmd_arg); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stretch();
        int unsigned t1, t2;
        bus.spi_ss = 1'b0; bus.spi_mosi = 1'b1;
        repeat (4) @(negedge clk);
        bus.spi_sck = 1'b1; t1 = cyc + 1;
        wait_until(t1 + 1);
        checks++; if (bus.led_user !== 1'b0) begin failures++; $display("FAIL stretch_pre_rise: %b expected 0", bus.led_user); end
        wait_until(t1 + 2);
        checks++; if (bus.led_user !== 1'b1) begin failures++; $display("FAIL stretch_rise: %b expected 1", bus.led_user); end
        wait_until(t1 + 4);  bus.spi_sck = 1'b0;
        wait_until(t1 + 50); bus.spi_sck = 1'b1; t2 = cyc + 1;
        wait_until(t1 + 54); bus.spi_sck = 1'b0;
        wait_until(t1 + 101);
        checks++; if (bus.led_user !== 1'b1) begin failures++; $display("FAIL stretch_restart: %b expected 1", bus.led_user); end
        wait_until(t2 + 100);
        checks++; if (bus.led_user !== 1'b1) begin failures++; $display("FAIL stretch_last_on: %b expected 1", bus.led_user); end
        checks++; if (bus.led_disk !== (CMDLOG ? 2'b00 : 2'b01)) begin failures++; $display("FAIL stretch_disk_on: %b expected %b", bus.led_disk, (CMDLOG ? 2'b00 : 2'b01)); end
        wait_until(t2 + 101);
        checks++; if (bus.led_user !== 1'b0) begin failures++; $display("FAIL stretch_off: %b expected 0", bus.led_user); end
        checks++; if (bus.led_disk !== 2'b00) begin failures++; $display("FAIL stretch_disk_off: %b expected 00", bus.led_disk); end
        bus.spi_ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cmd17();
        send_frame(6'd17, 32'h0000_1000, 8'hFF, CMDLOG, 1'b0);
        checks++; if (bus.cmd_index !== (CMDLOG ? 6'd17 : 6'd0)) begin failures++; $display("FAIL cmd17_index: %0d expected %0d", bus.cmd_index, (CMDLOG ? 6'd17 : 6'd0)); end
        checks++; if (bus.cmd_arg !== (CMDLOG ? 32'h0000_1000 : 32'h0)) begin failures++; $display("FAIL cmd17_arg: %h expected %h", bus.cmd_arg, (CMDLOG ? 32'h0000_1000 : 32'h0)); end
        wait_until(last_rise + 4);
        checks++; if (bus.led_disk !== 2'b01) begin failures++; $display("FAIL cmd17_led_disk: %b expected 01", bus.led_disk); end
        bus.spi_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ss_abort();
        bus.spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h58, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        bus.spi_ss = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (bus.cmd_index !== (CMDLOG ? 6'd17 : 6'd0)) begin failures++; $display("FAIL abort_index_kept: %0d expected %0d", bus.cmd_index, (CMDLOG ? 6'd17 : 6'd0)); end
        send_frame(6'd25, 32'h0000_0200, 8'hFF, CMDLOG, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_index !== (CMDLOG ? 6'd25 : 6'd0)) begin failures++; $display("FAIL cmd25_index: %0d expected %0d", bus.cmd_index, (CMDLOG ? 6'd25 : 6'd0)); end
        bus.spi_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ss_same_cycle();
        // SS rises together with the final CRC SCK edge: frame must be dropped
        send_frame(6'd24, 32'h1234_5678, 8'hFF, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (bus.cmd_arg !== (CMDLOG ? 32'h0000_0200 : 32'h0)) begin failures++; $display("FAIL same_cycle_arg_kept: %h expected %h", bus.cmd_arg, (CMDLOG ? 32'h0000_0200 : 32'h0)); end
    endtask

    task automatic test_reset_mid_arg();
        bus.spi_ss = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h58, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.led_user !== 1'b0) begin failures++; $display("FAIL midreset_led_user: %b expected 0", bus.led_user); end
        checks++; if (bus.led_disk !== 2'b00) begin failures++; $display("FAIL midreset_led_disk: %b expected 00", bus.led_disk); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: %b expected 0", bus.busy); end
        checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL midreset_cmd_valid: %b expected 0", bus.cmd_valid); end
        checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL midreset_cmd_index: %0d expected 0", bus.cmd_index); end
        checks++; if (bus.cmd_arg !== 32'd0) begin failures++; $display("FAIL midreset_cmd_arg: %h expected 0", bus.cmd_arg); end
        @(negedge clk);
        reset = 1'b0;
        bus.spi_ss = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(6'd18, 32'hDEAD_BEEF, 8'h01, CMDLOG, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_arg !== (CMDLOG ? 32'hDEAD_BEEF : 32'h0)) begin failures++; $display("FAIL post_reset_arg: %h expected %h", bus.cmd_arg, (CMDLOG ? 32'hDEAD_BEEF : 32'h0)); end
        bus.spi_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_cmd0();
        repeat (120) @(negedge clk);
        send_frame(6'd0, 32'h0, 8'h95, CMDLOG, 1'b0);
        wait_until(last_rise + 4);
        checks++; if (bus.cmd_index !== 6'd0) begin failures++; $display("FAIL cmd0_index: %0d expected 0", bus.cmd_index); end
        checks++; if (bus.led_user !== 1'b1) begin failures++; $display("FAIL cmd0_led_user: %b expected 1", bus.led_user); end
        checks++; if (bus.led_disk !== (CMDLOG ? 2'b00 : 2'b01)) begin failures++; $display("FAIL cmd0_led_disk: %b expected %b", bus.led_disk, (CMDLOG ? 2'b00 : 2'b01)); end
        wait_until(last_rise + 30);
        checks++; if (bus.led_disk !== (CMDLOG ? 2'b00 : 2'b01)) begin failures++; $display("FAIL cmd0_led_disk_late: %b expected %b", bus.led_disk, (CMDLOG ? 2'b00 : 2'b01)); end
        bus.spi_ss = 1'b1;
    endtask

    task automatic test_busy();
        int unsigned c0;
        repeat (60) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_quiet: %b expected 0", bus.busy); end
        c0 = cyc;
        bus.spi_mosi = ~bus.spi_mosi;
        wait_until(c0 + 2);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_pre_toggle: %b expected 0", bus.busy); end
        wait_until(c0 + 3);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_rise: %b expected 1", bus.busy); end
        wait_until(c0 + 52);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_last_high: %b expected 1", bus.busy); end
        wait_until(c0 + 53);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_timeout: %b expected 0", bus.busy); end
        repeat (5) @(negedge clk);
        c0 = cyc;
        bus.spi_mosi = ~bus.spi_mosi;
        wait_until(c0 + 40);
        bus.spi_miso = ~bus.spi_miso;
        wait_until(c0 + 53);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_miso_restart: %b expected 1", bus.busy); end
        wait_until(c0 + 92);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_miso_last_high: %b expected 1", bus.busy); end
        wait_until(c0 + 93);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_miso_timeout: %b expected 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_stretch();
        test_cmd17();
        test_ss_abort();
        test_ss_same_cycle();
        test_reset_mid_arg();
        test_cmd0();
        test_busy();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL frames_pending: %0d frames never decoded, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
